dmux_dispatch_ctrl: RTL
=======================

# dmux_dispatch_ctrl

Sequencing controller for the 1xN demultiplexer. Accepts words on a valid/ready input port and holds each word in a one-entry buffer. Drives the demux select and a one-hot output-valid vector until the addressed channel accepts the word. Supports two destination policies, addressed and round-robin, with a stall timeout that skips non-responding channels in round-robin mode.

## Interface
- N, 8: number of output channels, 2..256; select width SW = $clog2(N).
- W, 8: data width.
- MAX_WAIT, 15: stalled SEND cycles before a round-robin skip; 0 disables the timeout.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode_rr  in  1  1 = round-robin destination, 0 = addressed (in_dest).
- in_valid  in  1  input word valid.
- in_data  in  W  input word.
- in_dest  in  SW  destination channel, used when mode_rr=0.
- in_ready  out  1  controller can accept a word this cycle.
- out_ready  in  N  per-channel accept.
- Sel  out  SW  demux select, equals held destination.
- Y_valid  out  N  one-hot valid for channel Sel; all zero when idle.
- Y_data  out  W  held word.
- busy  out  1  high in SEND.
- skip  out  1  one-cycle pulse on a round-robin timeout retarget.
- err  out  1  one-cycle pulse when an invalid in_dest is dropped.
- xfer_count  out  16  completed transfers (see Configuration).

## Operation
- States: IDLE (buffer empty) and SEND (buffer full).
- Reset values: state IDLE, Sel=0, Y_valid=0, Y_data=0, rr_ptr=0, wait_cnt=0, skip=0, err=0, xfer_count=0.
- Reset is asynchronous and can occur mid-operation. A held word is discarded and there is no partial transfer.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) || (state==SEND && out_ready[Sel]). In-flight completion and a new accept in the same cycle give back-to-back throughput.
- Destination is resolved at accept:
  - mode_rr=1: dest = rr_ptr.
  - mode_rr=0: dest = in_dest.
  - mode_rr is sampled only at accept; changes during SEND are ignored.
- Invalid destination (mode_rr=0, in_dest ≥ N, possible only when N is not a power of 2):
  - The word is accepted and dropped.
  - err pulses next cycle.
  - State does not enter SEND (it stays, or returns to, IDLE).
- Transfer completes in SEND when out_ready[Sel]=1:
  - xfer_count increments, saturating at 16'hFFFF.
  - In round-robin mode, rr_ptr = (Sel==N-1) ? 0 : Sel+1.
  - Next state is SEND if a new word is accepted in the same cycle, else IDLE.
- Stall handling:
  - wait_cnt increments each SEND cycle with out_ready[Sel]=0, and clears on completion or on a new load.
  - Round-robin word with MAX_WAIT≠0 and wait_cnt==MAX_WAIT-1 during a stalled cycle:
    - Sel advances to the next channel modulo N, with wrap N-1→0.
    - wait_cnt clears and skip pulses.
    - The word is retained.
  - Addressed words never time out.
- If no channel is ever ready, round-robin retargeting rotates indefinitely. Words are never dropped.
- Y_valid = busy ? (1<<Sel) : 0. Y_data changes only on load.

## Timing
- All outputs are registered except in_ready, which is combinational from state, Sel and out_ready.
- Latency is 1 cycle: a word accepted at edge k appears on Sel/Y_valid/Y_data after edge k.
- Sustained throughput is one word per cycle while the targeted channels stay ready.
- A skip retarget takes effect on the edge of the MAX_WAIT-th stalled cycle. The new channel is presented on the next cycle.
- err and skip are single-cycle pulses, registered.

## Configuration
- DMUX_DISPATCH_STATS_EN defined:
  - xfer_count is a live 16-bit saturating counter, cleared only by rst_n.
  - A second internal 16-bit saturating skip counter is observable hierarchically as skip_total.
- Not defined:
  - xfer_count is tied to 16'h0 and both counters are removed.
  - All other behaviour is identical.

## Test plan
- Reset then addressed mode (N=8), out_ready=8'hFF, send in_data=8'hA5 with in_dest=3 → after next edge Sel=3, Y_valid=8'h08, Y_data=8'hA5. Transfer completes that cycle and in_ready stays 1.
- Round-robin mode with all channels ready: send 10 words back-to-back → Sel sequence 0,1,…,7,0,1. in_ready is held 1, and xfer_count=10 with the macro defined.
- Round-robin mode, out_ready=8'hFB (channel 2 stuck), MAX_WAIT=15 → a word targeting 2 stalls for 15 cycles. skip then pulses, Sel=3, and the transfer completes the following cycle.
- Addressed mode, in_dest=5 with out_ready[5]=0 for 40 cycles → Sel holds 5, in_ready=0, no skip. On release the word transfers and the state returns to IDLE.
- Reset mid-SEND: assert rst_n=0 asynchronously between edges → Y_valid=0, Sel=0 and busy=0 immediately. The held word is not delivered after release.
- N=6, addressed, in_dest=7 → word accepted, err pulses one cycle, Y_valid stays 0.

Source files
------------

// File: rtl/dmux_dispatch_ctrl.sv
// One-entry dispatch controller for a 1xN demux: addressed or round-robin destinations, with a stall-timeout skip.
// Optional statistics counters (xfer_count, skip_total) are enabled by defining DMUX_DISPATCH_STATS_EN.
module dmux_dispatch_ctrl #(
  parameter int N        = 8,
  parameter int W        = 8,
  parameter int MAX_WAIT = 15,
  localparam int SW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode_rr,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] in_dest,
  output logic          in_ready,
  input  logic [N-1:0]  out_ready,
  output logic [SW-1:0] Sel,
  output logic [N-1:0]  Y_valid,
  output logic [W-1:0]  Y_data,
  output logic          busy,
  output logic          skip,
  output logic          err,
  output logic [15:0]   xfer_count
);

  localparam int WCW            = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [SW:0] NL    = N[SW:0];
  localparam logic [SW-1:0] LAST = SW'(N - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         r_state;
  logic [SW-1:0]  r_sel;
  logic [N-1:0]   r_yvalid;
  logic [W-1:0]   r_data;
  logic           r_busy;
  logic           r_skip;
  logic           r_err;
  logic           r_rr_word;
  logic [SW-1:0]  r_rr_ptr;
  logic [WCW-1:0] r_wait;

  logic           w_sel_ready;
  logic           w_in_ready;
  logic           w_accept;
  logic           w_complete;
  logic           w_bad;
  logic           w_load;
  logic           w_skip_now;
  logic [SW-1:0]  w_rr_ptr_nxt;
  logic [SW-1:0]  w_dest;
  logic [SW-1:0]  w_sel_inc;

  function automatic logic [SW-1:0] next_ch(input logic [SW-1:0] s);
    return (s == LAST) ? '0 : s + 1'b1;
  endfunction

  always_comb begin
    w_sel_ready  = out_ready[r_sel];
    w_in_ready   = (r_state == IDLE) || w_sel_ready;
    w_accept     = in_valid && w_in_ready;
    w_complete   = (r_state == SEND) && w_sel_ready;
    w_sel_inc    = next_ch(r_sel);
    // A completion in the same cycle as a round-robin accept hands the new word the advanced pointer.
    w_rr_ptr_nxt = (w_complete && r_rr_word) ? w_sel_inc : r_rr_ptr;
    w_dest       = mode_rr ? w_rr_ptr_nxt : in_dest;
    w_bad        = !mode_rr && ({1'b0, in_dest} >= NL);
    w_load       = w_accept && !w_bad;
    w_skip_now   = (r_state == SEND) && !w_sel_ready && r_rr_word &&
                   (MAX_WAIT != 0) && (r_wait == WAIT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_yvalid  <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_skip    <= 1'b0;
      r_err     <= 1'b0;
      r_rr_word <= 1'b0;
      r_rr_ptr  <= '0;
      r_wait    <= '0;
    end else begin
      r_skip   <= 1'b0;
      r_err    <= w_accept && w_bad;
      r_rr_ptr <= w_rr_ptr_nxt;
      if (w_load) begin
        r_state   <= SEND;
        r_busy    <= 1'b1;
        r_sel     <= w_dest;
        r_yvalid  <= {{(N-1){1'b0}}, 1'b1} << w_dest;
        r_data    <= in_data;
        r_rr_word <= mode_rr;
        r_wait    <= '0;
      end else if (w_complete) begin
        r_state  <= IDLE;
        r_busy   <= 1'b0;
        r_yvalid <= '0;
        r_wait   <= '0;
      end else if (r_state == SEND) begin
        if (w_skip_now) begin
          r_sel    <= w_sel_inc;
          r_yvalid <= {{(N-1){1'b0}}, 1'b1} << w_sel_inc;
          r_wait   <= '0;
          r_skip   <= 1'b1;
        end else begin
          r_wait <= r_wait + 1'b1;
        end
      end
    end
  end

`ifdef DMUX_DISPATCH_STATS_EN
  logic [15:0] r_xfer_count;
  logic [15:0] skip_total;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_count <= '0;
      skip_total   <= '0;
    end else begin
      if (w_complete && (r_xfer_count != '1)) r_xfer_count <= r_xfer_count + 1'b1;
      if (w_skip_now && (skip_total != '1))   skip_total   <= skip_total + 1'b1;
    end
  end

  assign xfer_count = r_xfer_count;
`else
  assign xfer_count = '0;
`endif

  assign in_ready = w_in_ready;
  assign Sel      = r_sel;
  assign Y_valid  = r_yvalid;
  assign Y_data   = r_data;
  assign busy     = r_busy;
  assign skip     = r_skip;
  assign err      = r_err;

endmodule
